// File: rtl/mem_op_sequencer_pkg.sv
// Shared mode/stage codes and the sequencer state enum; the display driver
// imports the same mode constants.
package mem_ctrl_pkg;

  localparam logic [1:0] CLEARMODE = 2'b00;
  localparam logic [1:0] READMODE  = 2'b01;
  localparam logic [1:0] WRITEMODE = 2'b10;
  localparam logic [1:0] IDLE      = 2'b11;

  localparam logic [1:0] STG_PROMPT = 2'b00;
  localparam logic [1:0] STG_ADDR   = 2'b01;
  localparam logic [1:0] STG_MID    = 2'b10;
  localparam logic [1:0] STG_SHOW   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PROMPT,
    S_ADDR,
    S_DATA,
    S_WR,
    S_RD,
    S_RDWAIT,
    S_SHOW,
    S_CLEAR
  } state_t;

endpackage

// File: rtl/mem_op_sequencer_if.sv
// Operator, RAM and display bundle of the memory operation sequencer.
interface mem_op_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  // btn_next/btn_cancel are single-cycle pulses sampled on the rising clock
  // edge; there is no valid/ready back-pressure, busy is status only.
  logic [1:0]        mode_sw;
  logic [DATA_W-1:0] entry_val;
  logic              btn_next;
  logic              btn_cancel;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic [1:0]        mode_select;
  logic [1:0]        stage;
  logic [DATA_W-1:0] disp_val;
  logic              busy;

  modport slave (
    input  mode_sw, entry_val, btn_next, btn_cancel, mem_rdata,
    output mem_addr, mem_wdata, mem_we, mode_select, stage, disp_val, busy
  );

  modport master (
    output mode_sw, entry_val, btn_next, btn_cancel, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, mode_select, stage, disp_val, busy
  );
endinterface

// File: rtl/mem_op_sequencer_clear_sweep.sv
// Address sweep for CLEAR: after a start pulse, walks 0..DEPTH-1 once with we
// high, then pulses done for one cycle.
module mem_clear_sweep #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              we_o,
  output logic              done_o
);

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              active_q, active_d;
  logic              done_q, done_d;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = 1'b0;
    if (start_i) begin
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {ADDR_W{1'b1}}) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign addr_o = cnt_q;
  assign we_o   = active_q;
  assign done_o = done_q;

endmodule

// File: rtl/mem_op_sequencer.sv
// Operator-driven CLEAR/READ/WRITE sequencer feeding the seven-segment display.
// Build option MEM_OP_AUTO_INC_EN: step in SHOW advances to the next address.
module mem_op_sequencer
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  mem_op_sequencer_if.slave   bus,
  output state_t              dbg_state_o
);

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [1:0]        mode_select_q, mode_select_d;
  logic [1:0]        stage_q, stage_d;
  logic [DATA_W-1:0] disp_val_q, disp_val_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;

  logic              sweep_start;
  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_we;
  logic              sweep_done;
  logic              cancel_ok;

  mem_clear_sweep #(.ADDR_W(ADDR_W)) u_sweep (
    .clk     (clk),
    .rst     (rst),
    .start_i (sweep_start),
    .addr_o  (sweep_addr),
    .we_o    (sweep_we),
    .done_o  (sweep_done)
  );

  // A cancel landing on an in-flight RAM access or sweep is dropped.
  assign cancel_ok = !(state_q inside {S_CLEAR, S_WR, S_RDWAIT});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mode_q        <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      mode_select_q <= IDLE;
      stage_q       <= STG_PROMPT;
      disp_val_q    <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      mode_select_q <= mode_select_d;
      stage_q       <= stage_d;
      disp_val_q    <= disp_val_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sweep_start = 1'b0;
    if (bus.btn_cancel && cancel_ok) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.btn_next) begin
            case (bus.mode_sw)
              CLEARMODE: begin
                state_d     = S_CLEAR;
                sweep_start = 1'b1;
              end
              READMODE, WRITEMODE: begin
                mode_d  = bus.mode_sw;
                state_d = S_PROMPT;
              end
              default: ;
            endcase
          end
        end
        S_PROMPT: if (bus.btn_next) state_d = S_ADDR;
        S_ADDR: begin
          if (bus.btn_next) begin
            addr_d  = bus.entry_val[ADDR_W-1:0];
            state_d = (mode_q == READMODE) ? S_RD : S_DATA;
          end
        end
        S_DATA: begin
          if (bus.btn_next) begin
            wdata_d = bus.entry_val;
            state_d = S_WR;
          end
        end
        S_WR:     state_d = S_SHOW;
        S_RD:     state_d = S_RDWAIT;
        S_RDWAIT: state_d = S_SHOW;
        S_SHOW: begin
          if (bus.btn_next) begin
`ifdef MEM_OP_AUTO_INC_EN
            addr_d  = addr_q + 1'b1;
            state_d = (mode_q == READMODE) ? S_RD : S_DATA;
`else
            state_d = S_IDLE;
`endif
          end
        end
        S_CLEAR:  if (sweep_done) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    case (state_d)
      S_IDLE:  mode_select_d = IDLE;
      S_CLEAR: mode_select_d = CLEARMODE;
      default: mode_select_d = mode_d;
    endcase

    case (state_d)
      S_ADDR:                       stage_d = STG_ADDR;
      S_DATA, S_WR, S_RD, S_RDWAIT: stage_d = STG_MID;
      S_SHOW:                       stage_d = STG_SHOW;
      default:                      stage_d = STG_PROMPT;
    endcase

    busy_d      = state_d inside {S_WR, S_RD, S_RDWAIT, S_CLEAR};
    mem_we_d    = (state_d == S_WR) || ((state_d == S_CLEAR) && sweep_we);
    mem_addr_d  = (state_d == S_CLEAR) ? sweep_addr : addr_d;
    mem_wdata_d = mem_wdata_q;
    if (state_d == S_WR)    mem_wdata_d = wdata_d;
    if (state_d == S_CLEAR) mem_wdata_d = '0;

    case (state_d)
      S_ADDR, S_DATA:   disp_val_d = bus.entry_val;
      S_WR:             disp_val_d = wdata_d;
      S_RD, S_RDWAIT:   disp_val_d = disp_val_q;
      S_SHOW:           disp_val_d = (state_q == S_RDWAIT) ? bus.mem_rdata : disp_val_q;
      default:          disp_val_d = '0;
    endcase
  end

  assign bus.mode_select = mode_select_q;
  assign bus.stage       = stage_q;
  assign bus.disp_val    = disp_val_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.busy        = busy_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Directed bench for mem_op_sequencer with a synchronous RAM model and a
// write scoreboard fed by exp_q.
module tb_mem_op_sequencer;
  import mem_ctrl_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic   clk;
  logic   rst;
  state_t dut_state;
  int     checks;
  int     errors;
  int     we_cnt;

  logic [25:0] exp_q[$];
  logic [15:0] ram [DEPTH];

  mem_op_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(16)) bus ();

  mem_op_sequencer #(.ADDR_W(ADDR_W), .DATA_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dut_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

  // synchronous single-port RAM, read data one cycle after the address
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // every write cycle must match the head of exp_q, busy included
  always @(negedge clk) begin
    if (!rst && bus.mem_we) begin
      logic [25:0] exp_w;
      exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 26'h0;
      chk("mem_write", {6'h0, 1'b1, bus.busy, bus.mem_addr, bus.mem_wdata}, {6'h0, exp_w});
      we_cnt++;
    end
  end

  // driver tasks
  task automatic press_next();
    @(negedge clk);
    bus.btn_next = 1'b1;
    @(negedge clk);
    bus.btn_next = 1'b0;
  endtask

  task automatic pulse_cancel();
    @(negedge clk);
    bus.btn_cancel = 1'b1;
    @(negedge clk);
    bus.btn_cancel = 1'b0;
  endtask

  task automatic do_read_show(input logic [7:0] a, input logic [15:0] d, input string tag);
    bus.mode_sw = READMODE;
    press_next();
    chk({tag, "_prompt_mode"}, 32'(bus.mode_select), 32'(READMODE));
    chk({tag, "_prompt_stage"}, 32'(bus.stage), 32'(STG_PROMPT));
    bus.entry_val = {8'hC3, a};
    press_next();
    @(negedge clk);
    chk({tag, "_addr_live"}, 32'(bus.disp_val), {16'h0, 8'hC3, a});
    press_next();
    chk({tag, "_rd_addr"}, 32'(bus.mem_addr), 32'(a));
    chk({tag, "_rd_busy"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk({tag, "_rdwait_stage"}, 32'(bus.stage), 32'(STG_MID));
    @(negedge clk);
    chk({tag, "_show_stage"}, 32'(bus.stage), 32'(STG_SHOW));
    chk({tag, "_show_val"}, 32'(bus.disp_val), 32'(d));
  endtask

  task automatic do_read(input logic [7:0] a, input logic [15:0] d, input string tag);
    do_read_show(a, d, tag);
    pulse_cancel();
    chk({tag, "_cancel_idle"}, 32'(dut_state), 32'(S_IDLE));
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d, input string tag);
    bus.mode_sw = WRITEMODE;
    press_next();
    chk({tag, "_prompt_mode"}, 32'(bus.mode_select), 32'(WRITEMODE));
    bus.mode_sw   = CLEARMODE;
    bus.entry_val = {8'h5A, a};
    press_next();
    press_next();
    chk({tag, "_data_stage"}, 32'(bus.stage), 32'(STG_MID));
    chk({tag, "_data_addr"}, 32'(bus.mem_addr), 32'(a));
    bus.entry_val = d;
    @(negedge clk);
    chk({tag, "_data_live"}, 32'(bus.disp_val), 32'(d));
    chk({tag, "_mode_held"}, 32'(bus.mode_select), 32'(WRITEMODE));
    exp_q.push_back({2'b11, a, d});
    press_next();
    chk({tag, "_wr_busy"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk({tag, "_show_stage"}, 32'(bus.stage), 32'(STG_SHOW));
    chk({tag, "_show_val"}, 32'(bus.disp_val), 32'(d));
    chk({tag, "_we_low"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_all_written"}, 32'(exp_q.size()), 32'd0);
    pulse_cancel();
    chk({tag, "_cancel_idle"}, 32'(dut_state), 32'(S_IDLE));
  endtask

  initial begin
    int we_start;
    checks         = 0;
    errors         = 0;
    we_cnt         = 0;
    rst            = 1'b1;
    bus.mode_sw    = IDLE;
    bus.entry_val  = '0;
    bus.btn_next   = 1'b0;
    bus.btn_cancel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mode", 32'(bus.mode_select), 32'(IDLE));
    chk("rst_stage", 32'(bus.stage), 32'(STG_PROMPT));
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_disp", 32'(bus.disp_val), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;

    // idle mode ignores step
    press_next();
    chk("idle_stay_state", 32'(dut_state), 32'(S_IDLE));
    chk("idle_stay_mode", 32'(bus.mode_select), 32'(IDLE));

    // clear sweep with a cancel that must be dropped
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({2'b11, 8'(i), 16'h0000});
    we_start    = we_cnt;
    bus.mode_sw = CLEARMODE;
    press_next();
    chk("clr_mode", 32'(bus.mode_select), 32'(CLEARMODE));
    chk("clr_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 2 * DEPTH && dut_state != S_IDLE; i++) begin
      bus.btn_cancel = (i == 20);
      @(negedge clk);
    end
    bus.btn_cancel = 1'b0;
    chk("clr_done_state", 32'(dut_state), 32'(S_IDLE));
    chk("clr_we_count", 32'(we_cnt - we_start), 32'(DEPTH));
    chk("clr_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("clr_end_mode", 32'(bus.mode_select), 32'(IDLE));
    chk("clr_end_busy", 32'(bus.busy), 32'd0);
    do_read(8'h05, 16'h0000, "rd5");

    // write then read back
    do_write(8'h3A, 16'hBEEF, "wr3a");
    do_read(8'h3A, 16'hBEEF, "rd3a");

    // next and cancel together in DATA: cancel wins, nothing written
    bus.mode_sw = WRITEMODE;
    press_next();
    bus.entry_val = 16'h0010;
    press_next();
    press_next();
    bus.entry_val = 16'h5555;
    @(negedge clk);
    bus.btn_next   = 1'b1;
    bus.btn_cancel = 1'b1;
    @(negedge clk);
    bus.btn_next   = 1'b0;
    bus.btn_cancel = 1'b0;
    chk("nc_state", 32'(dut_state), 32'(S_IDLE));
    chk("nc_mode", 32'(bus.mode_select), 32'(IDLE));
    @(negedge clk);
    do_read(8'h10, 16'h0000, "rd10");

    // async reset during the write cycle
    bus.mode_sw = WRITEMODE;
    press_next();
    bus.entry_val = 16'h0020;
    press_next();
    press_next();
    bus.entry_val = 16'h1111;
    @(negedge clk);
    bus.btn_next = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_we", 32'(bus.mem_we), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_state", 32'(dut_state), 32'(S_IDLE));
    chk("arst_mode", 32'(bus.mode_select), 32'(IDLE));
    chk("arst_stage", 32'(bus.stage), 32'(STG_PROMPT));
    chk("arst_disp", 32'(bus.disp_val), 32'd0);
    chk("arst_addr", 32'(bus.mem_addr), 32'd0);
    chk("arst_wdata", 32'(bus.mem_wdata), 32'd0);
    bus.btn_next = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_read(8'h20, 16'h0000, "rd20");

    // top-of-range address and what a step in SHOW does
    do_write(8'h00, 16'h1357, "wr00");
    do_write(8'hFF, 16'hCAFE, "wrff");
    do_read_show(8'hFF, 16'hCAFE, "rdff");
`ifdef MEM_OP_AUTO_INC_EN
    press_next();
    chk("inc_wrap_addr", 32'(bus.mem_addr), 32'd0);
    chk("inc_stage", 32'(bus.stage), 32'(STG_MID));
    @(negedge clk);
    @(negedge clk);
    chk("inc_show_stage", 32'(bus.stage), 32'(STG_SHOW));
    chk("inc_show_val", 32'(bus.disp_val), 32'h1357);
    pulse_cancel();
    chk("inc_cancel_idle", 32'(dut_state), 32'(S_IDLE));
`else
    press_next();
    chk("show_next_state", 32'(dut_state), 32'(S_IDLE));
    chk("show_next_mode", 32'(bus.mode_select), 32'(IDLE));
`endif

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
